audio_i2s_tone_tx: RTL
======================

// Module: audio_i2s_tone_tx
// PURPOSE
//  Consumer end of the note-divider path. Converts the selected left/right note dividers into
//  two square-wave tones and sends them as 16-bit two's-complement samples over the I2S
//  link (mclk/lrck/sck/sdin) to the speaker Pmod. Sits between the note selector and the pins.
// PARAMETERS
//  AMPLITUDE  16'sd8192  tone peak magnitude; samples are +AMPLITUDE / -AMPLITUDE / 0
//  MIN_DIV    22'd2      any note_div below this is silence (sample 0, tone counter held at 0)
// PORTS
//  clk             input   1   system clock (100 MHz)
//  rst_n           input   1   asynchronous reset, active low
//  note_div_left   input   22  left tone divider; tone freq = f_clk/(2*note_div_left)
//  note_div_right  input   22  right tone divider, same rule
//  mute            input   1   1 = both samples forced to 0; sampled at frame latch
//  audio_mclk      output  1   master clock = clk/4
//  audio_lrck      output  1   word select = clk/512; 0 = left slot, 1 = right slot
//  audio_sck       output  1   bit clock = clk/8 (32 sck periods per slot)
//  audio_sdin      output  1   serial data, MSB first, changes on sck falling edge
// BEHAVIOUR
//  Reset: every output 0; all counters, phases, div copies, shadow samples 0. Async assert, no clock needed.
//  Timebase: free-running 9-bit fcnt, +1 per clk, wraps 511->0.
//   audio_mclk=fcnt[1], audio_sck=fcnt[2], audio_lrck=fcnt[8]; all driven from registered fcnt bits.
//  Tone generator (one per channel, identical):
//   - div_q holds last note_div. Edge where note_div != div_q: div_q<=note_div, tcnt<=0, phase<=0.
//   - Else if div_q < MIN_DIV: tcnt held 0, phase held 0.
//   - Else tcnt+1 per clk; at tcnt==div_q-1: tcnt<=0, phase<=~phase.
//     First toggle after a divider change is exactly div_q clk edges after the change edge.
//   - Live sample: 0 if div_q<MIN_DIV; else phase?-AMPLITUDE:+AMPLITUDE (16-bit).
//  Frame latch: on the edge where fcnt wraps 511->0, both live samples go into shadow_l/shadow_r.
//   If mute=1 at that edge, 0 is latched instead.
//   Both slots of one frame always come from the same latch. Divider changes mid-frame
//   affect only the next frame.
//  Serializer: slot bit index k = fcnt[7:3] (0..31), slot = fcnt[8].
//   - sdin during index k: k=0 -> 0 (I2S 1-bit delay); k=1..16 -> shadow[16-k]; k=17..31 -> 0.
//   - sdin is a register, updated on the edge where fcnt[2:0] wraps 7->0, i.e. aligned with sck falling.
//   - First frame after reset: shadows are 0, so sdin is all zero.
//  Widths: tcnt 22 bits; compare against div_q-1 only when div_q>=MIN_DIV (no underflow).
//   note_div = 22'h3FFFFF is legal.
//  Reset mid-operation: immediate return to reset state; on release the timebase restarts at fcnt=0.
// TESTING
//  1. rst_n low 5 clk then high -> outputs 0 during reset; after release mclk period 4, sck period 8,
//     lrck period 512 clk, first lrck rise at clk 256.
//  2. note_div_left=note_div_right=0 for 3 frames -> sdin constantly 0.
//  3. left=22'd100000, right=22'd100000 (phase 0) -> left and right slots each carry
//     0,0010_0000_0000_0000, then 15 zeros.
//  4. left=22'd8 -> left phase toggles every 8 clk (check internally). Each latched left word is
//     16'h2000 or 16'hE000; right word 16'h0000.
//  5. left changes 100000->50 mid-frame -> tcnt cleared that edge; next toggle exactly 50 clk later;
//     current frame's serialized word unchanged.
//  6. mute=1 at a frame latch with tones active -> that frame both words 0; mute=0 at next latch -> tone resumes.
//  7. rst_n pulsed low at fcnt=200 with no clk edge -> all outputs 0 at once; timebase restarts at 0 after release.

Source files
------------

// File: rtl/audio_i2s_tone_tx_if.sv
// Pin-side bundle of the tone transmitter: note dividers and mute in, I2S pins out.
// master = note selector side, slave = the transmitter.
interface audio_i2s_tone_tx_if;
   logic [21:0] note_div_left;
   logic [21:0] note_div_right;
   logic        mute;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic        audio_sdin;

   modport master (
      output note_div_left, note_div_right, mute,
      input  audio_mclk, audio_lrck, audio_sck, audio_sdin
   );

   modport slave (
      input  note_div_left, note_div_right, mute,
      output audio_mclk, audio_lrck, audio_sck, audio_sdin
   );
endinterface

// File: rtl/audio_i2s_tone_tx.sv
// Two square-wave tone generators feeding a 16-bit I2S serializer.
// The 512-clk frame timebase also supplies mclk, sck and lrck straight from its register bits.
module audio_i2s_tone_tx #(
   parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
   parameter logic [21:0]        MIN_DIV   = 22'd2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   audio_i2s_tone_tx_if.slave   bus
);

   localparam logic [15:0] POS_SAMPLE = AMPLITUDE;
   localparam logic [15:0] NEG_SAMPLE = 16'(-AMPLITUDE);

   logic [8:0]  fcnt;
   logic [8:0]  fcnt_next;
   logic        frame_wrap;
   logic        bit_wrap;

   logic [21:0] note_div [2];
   logic [21:0] div_q    [2];
   logic [21:0] tcnt     [2];
   logic [1:0]  phase;
   logic [15:0] live     [2];

   logic [15:0] shadow_l;
   logic [15:0] shadow_r;
   logic [15:0] word;
   logic [4:0]  bit_idx;
   logic        bit_val;
   logic        sdin_q;

   assign note_div[0] = bus.note_div_left;
   assign note_div[1] = bus.note_div_right;

   assign fcnt_next  = fcnt + 9'd1;
   assign frame_wrap = (fcnt == 9'd511);
   assign bit_wrap   = (fcnt[2:0] == 3'b111);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
      end else begin
         fcnt <= fcnt_next;
      end
   end

   // NOTE: the small per-channel arrays are register banks, not RAM, so they are reset like any flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            div_q[ch] <= '0;
            tcnt[ch]  <= '0;
            phase[ch] <= 1'b0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (note_div[ch] != div_q[ch]) begin
               div_q[ch] <= note_div[ch];
               tcnt[ch]  <= '0;
               phase[ch] <= 1'b0;
            end else if (div_q[ch] < MIN_DIV) begin
               tcnt[ch]  <= '0;
               phase[ch] <= 1'b0;
            end else if (tcnt[ch] == div_q[ch] - 22'd1) begin
               // Divider is >= MIN_DIV here, so div_q-1 cannot underflow.
               tcnt[ch]  <= '0;
               phase[ch] <= ~phase[ch];
            end else begin
               tcnt[ch]  <= tcnt[ch] + 22'd1;
            end
         end
      end
   end

   // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         live[ch] = '0;
         if (div_q[ch] >= MIN_DIV) begin
            live[ch] = phase[ch] ? NEG_SAMPLE : POS_SAMPLE;
         end
      end
   end

   // Both slots of a frame come from this single latch, so a mid-frame divider change waits a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_l <= '0;
         shadow_r <= '0;
      end else if (frame_wrap) begin
         shadow_l <= bus.mute ? 16'h0000 : live[0];
         shadow_r <= bus.mute ? 16'h0000 : live[1];
      end
   end

   // sdin is loaded for the bit slot that starts on this edge, which lines up with sck falling.
   assign bit_idx = fcnt_next[7:3];
   assign word    = fcnt_next[8] ? shadow_r : shadow_l;

   always_comb begin
      bit_val = 1'b0;
      if (bit_idx >= 5'd1 && bit_idx <= 5'd16) begin
         bit_val = word[4'(5'd16 - bit_idx)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdin_q <= 1'b0;
      end else if (bit_wrap) begin
         sdin_q <= bit_val;
      end
   end

   assign bus.audio_mclk = fcnt[1];
   assign bus.audio_sck  = fcnt[2];
   assign bus.audio_lrck = fcnt[8];
   assign bus.audio_sdin = sdin_q;

endmodule
